// File: rtl/monster_lane_shifter.sv
// -----------------------------------------------------------------------------
// monster_lane_shifter
//
// Lane scroller for the punch-zombie playfield. Holds LANES x DEPTH monster
// slots (kind codes, 0 = empty). On a scroll every lane moves one column
// toward the player (column 0) and a new kind is injected at column DEPTH-1.
// Punches are resolved against the pre-edge front column, and monsters that
// leave column 0 unpunched raise an escape pulse. Per-slot pictures are looked
// up from a static sprite table and registered alongside the kinds.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   shift      scroll strobe, honoured only while gaming=1
//   gaming     game running
//   ready      pre-game fill strobe, scrolls regardless of gaming
//   gameover   clear the playfield (beats hit and scroll)
//   spawn_kind per-lane kind injected at the spawn column on a scroll
//   hit        per-lane punch request (one-cycle pulse)
//   sprite_lut static sprite table, kind k>=1 at [(k-1)*PIX_W +: PIX_W]
//   kind_out   slot kinds, slot (l,c) at [(l*DEPTH+c)*KIND_W +: KIND_W]
//   pic_out    slot pictures, slot (l,c) at [(l*DEPTH+c)*PIX_W +: PIX_W]
//   hit_ok     punch landed on a monster (pulse)
//   miss       punch on an empty front slot (pulse)
//   escape     monster left column 0 unpunched (pulse)
//   live_cnt   number of non-empty slots
// -----------------------------------------------------------------------------
module monster_lane_shifter #(
    parameter int LANES  = 2,
    parameter int DEPTH  = 6,
    parameter int PIX_W  = 160,
    parameter int KIND_W = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 shift,
    input  logic                                 gaming,
    input  logic                                 ready,
    input  logic                                 gameover,
    input  logic [LANES*KIND_W-1:0]              spawn_kind,
    input  logic [LANES-1:0]                     hit,
    input  logic [(2**KIND_W-1)*PIX_W-1:0]       sprite_lut,
    output logic [LANES*DEPTH*KIND_W-1:0]        kind_out,
    output logic [LANES*DEPTH*PIX_W-1:0]         pic_out,
    output logic [LANES-1:0]                     hit_ok,
    output logic [LANES-1:0]                     miss,
    output logic [LANES-1:0]                     escape,
    output logic [$clog2(LANES*DEPTH+1)-1:0]     live_cnt
);

    localparam int NSLOT = LANES * DEPTH;
    localparam int CNT_W = $clog2(NSLOT + 1);
    localparam int NKIND = 2 ** KIND_W;

    logic [KIND_W-1:0] slot_q [LANES][DEPTH];
    logic [KIND_W-1:0] slot_d [LANES][DEPTH];
    logic [PIX_W-1:0]  pic_q  [LANES][DEPTH];
    logic [PIX_W-1:0]  sprite [NKIND];

    logic [LANES-1:0]  hit_ok_q, hit_ok_d;
    logic [LANES-1:0]  miss_q, miss_d;
    logic [LANES-1:0]  escape_q, escape_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              scroll;

    assign scroll = (gaming & shift) | ready;

    // Kind 0 maps to a blank picture, so the picture lookup needs no
    // separate empty-slot mux.
    assign sprite[0] = '0;
    generate
        for (genvar gi = 1; gi < NKIND; gi++) begin : g_sprite
            assign sprite[gi] = sprite_lut[(gi-1)*PIX_W +: PIX_W];
        end
    endgenerate

    always_comb begin
        logic front;
        slot_d   = slot_q;
        hit_ok_d = '0;
        miss_d   = '0;
        escape_d = '0;
        cnt_d    = '0;
        front    = 1'b0;

        if (gameover) begin
            for (int l = 0; l < LANES; l++) begin
                for (int c = 0; c < DEPTH; c++) begin
                    slot_d[l][c] = '0;
                end
            end
        end else begin
            for (int l = 0; l < LANES; l++) begin
                front = (slot_q[l][0] != '0);
                // The punch resolves the front monster before any scroll, so a
                // punched monster never counts as escaped.
                if (hit[l]) begin
                    hit_ok_d[l]  = front;
                    miss_d[l]    = ~front;
                    slot_d[l][0] = '0;
                end
                if (scroll) begin
                    for (int c = 0; c < DEPTH - 1; c++) begin
                        slot_d[l][c] = slot_q[l][c+1];
                    end
                    slot_d[l][DEPTH-1] = spawn_kind[l*KIND_W +: KIND_W];
                    escape_d[l]        = front & ~hit[l];
                end
            end
        end

        for (int l = 0; l < LANES; l++) begin
            for (int c = 0; c < DEPTH; c++) begin
                cnt_d = cnt_d + CNT_W'(slot_d[l][c] != '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int l = 0; l < LANES; l++) begin
                for (int c = 0; c < DEPTH; c++) begin
                    slot_q[l][c] <= '0;
                    pic_q[l][c]  <= '0;
                end
            end
            hit_ok_q <= '0;
            miss_q   <= '0;
            escape_q <= '0;
            cnt_q    <= '0;
        end else begin
            for (int l = 0; l < LANES; l++) begin
                for (int c = 0; c < DEPTH; c++) begin
                    slot_q[l][c] <= slot_d[l][c];
                    // Looked up from next-state kinds so picture and kind
                    // always change on the same edge.
                    pic_q[l][c]  <= sprite[slot_d[l][c]];
                end
            end
            hit_ok_q <= hit_ok_d;
            miss_q   <= miss_d;
            escape_q <= escape_d;
            cnt_q    <= cnt_d;
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            for (genvar gj = 0; gj < DEPTH; gj++) begin : g_col
                assign kind_out[(gi*DEPTH+gj)*KIND_W +: KIND_W] = slot_q[gi][gj];
                assign pic_out[(gi*DEPTH+gj)*PIX_W +: PIX_W]    = pic_q[gi][gj];
            end
        end
    endgenerate

    assign hit_ok   = hit_ok_q;
    assign miss     = miss_q;
    assign escape   = escape_q;
    assign live_cnt = cnt_q;

endmodule

// File: tb/tb_monster_lane_shifter.sv
module tb_monster_lane_shifter;

    localparam int LANES  = 2;
    localparam int DEPTH  = 6;
    localparam int PIX_W  = 160;
    localparam int KIND_W = 2;

    localparam logic [PIX_W-1:0] SPR1 = {5{32'h1111_0001}};
    localparam logic [PIX_W-1:0] SPR2 = {5{32'h2222_0002}};
    localparam logic [PIX_W-1:0] SPR3 = {5{32'h3333_0003}};

    logic                              clk = 1'b0;
    logic                              rst;
    logic                              shift;
    logic                              gaming;
    logic                              ready;
    logic                              gameover;
    logic [LANES*KIND_W-1:0]           spawn_kind;
    logic [LANES-1:0]                  hit;
    logic [(2**KIND_W-1)*PIX_W-1:0]    sprite_lut;
    logic [LANES*DEPTH*KIND_W-1:0]     kind_out;
    logic [LANES*DEPTH*PIX_W-1:0]      pic_out;
    logic [LANES-1:0]                  hit_ok;
    logic [LANES-1:0]                  miss;
    logic [LANES-1:0]                  escape;
    logic [$clog2(LANES*DEPTH+1)-1:0]  live_cnt;

    int total  = 0;
    int passed = 0;

    monster_lane_shifter #(
        .LANES(LANES), .DEPTH(DEPTH), .PIX_W(PIX_W), .KIND_W(KIND_W)
    ) dut (
        .clk(clk), .rst(rst), .shift(shift), .gaming(gaming), .ready(ready),
        .gameover(gameover), .spawn_kind(spawn_kind), .hit(hit),
        .sprite_lut(sprite_lut), .kind_out(kind_out), .pic_out(pic_out),
        .hit_ok(hit_ok), .miss(miss), .escape(escape), .live_cnt(live_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [KIND_W-1:0] kind_at(int l, int c);
        return kind_out[(l*DEPTH+c)*KIND_W +: KIND_W];
    endfunction

    function automatic logic [PIX_W-1:0] pic_at(int l, int c);
        return pic_out[(l*DEPTH+c)*PIX_W +: PIX_W];
    endfunction

    // One clock edge, then settle before sampling outputs.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; shift = 0; gaming = 0; ready = 0; gameover = 0;
        spawn_kind = '0; hit = '0;
    endtask

    task automatic test_reset();
        rst = 1; gaming = 1; shift = 1; ready = 1; hit = 2'b11; spawn_kind = 4'b1111;
        step(); step();
        total++;
        if (kind_out !== '0) $display("FAIL reset_kind: got %h want 0", kind_out);
        else passed++;
        total++;
        if (pic_out !== '0) $display("FAIL reset_pic: got nonzero want 0");
        else passed++;
        total++;
        if (live_cnt !== 0) $display("FAIL reset_cnt: got %0d want 0", live_cnt);
        else passed++;
        total++;
        if ({hit_ok, miss, escape} !== '0)
            $display("FAIL reset_pulses: got %b want 0", {hit_ok, miss, escape});
        else passed++;
        idle_inputs();
        $display("test_reset done");
    endtask

    task automatic test_scroll_through();
        gaming = 1; shift = 1; spawn_kind = 4'b0001;
        step();
        total++;
        if (kind_at(0, 5) !== 2'd1 || pic_at(0, 5) !== SPR1 || live_cnt !== 1)
            $display("FAIL spawn_slot: kind %0d cnt %0d want kind 1 cnt 1", kind_at(0, 5), live_cnt);
        else passed++;
        spawn_kind = '0;
        for (int i = 1; i <= 5; i++) begin
            step();
            total++;
            if (kind_at(0, 5-i) !== 2'd1 || escape !== 2'b00)
                $display("FAIL scroll_col%0d: kind %0d esc %b want 1 00", 5-i, kind_at(0, 5-i), escape);
            else passed++;
        end
        total++;
        if (pic_at(0, 0) !== SPR1 || live_cnt !== 1)
            $display("FAIL front_pic_cnt: cnt %0d want 1", live_cnt);
        else passed++;
        step();
        total++;
        if (escape !== 2'b01 || live_cnt !== 0 || kind_out !== '0)
            $display("FAIL escape: esc %b cnt %0d kind %h want 01 0 0", escape, live_cnt, kind_out);
        else passed++;
        shift = 0;
        step();
        total++;
        if (escape !== 2'b00) $display("FAIL escape_pulse: got %b want 00", escape);
        else passed++;
        idle_inputs();
        $display("test_scroll_through done");
    endtask

    task automatic test_punch();
        gaming = 1; shift = 1; spawn_kind = 4'b1000;
        step();
        spawn_kind = '0;
        for (int i = 0; i < 5; i++) step();
        shift = 0;
        total++;
        if (kind_at(1, 0) !== 2'd2 || pic_at(1, 0) !== SPR2 || live_cnt !== 1)
            $display("FAIL punch_setup: kind %0d cnt %0d want 2 1", kind_at(1, 0), live_cnt);
        else passed++;
        hit = 2'b10;
        step();
        total++;
        if (kind_at(1, 0) !== 2'd0 || hit_ok !== 2'b10 || miss !== 2'b00 || live_cnt !== 0)
            $display("FAIL punch_hit: kind %0d ok %b miss %b cnt %0d want 0 10 00 0",
                     kind_at(1, 0), hit_ok, miss, live_cnt);
        else passed++;
        hit = 2'b01;
        step();
        total++;
        if (miss !== 2'b01 || hit_ok !== 2'b00)
            $display("FAIL punch_miss: miss %b ok %b want 01 00", miss, hit_ok);
        else passed++;
        hit = 2'b00;
        step();
        total++;
        if (miss !== 2'b00 || hit_ok !== 2'b00)
            $display("FAIL punch_pulse: miss %b ok %b want 00 00", miss, hit_ok);
        else passed++;
        idle_inputs();
        $display("test_punch done");
    endtask

    task automatic test_hit_scroll();
        gaming = 1; shift = 1; spawn_kind = 4'b0011;
        step();
        spawn_kind = 4'b0001;
        step();
        spawn_kind = '0;
        for (int i = 0; i < 4; i++) step();
        total++;
        if (kind_at(0, 0) !== 2'd3 || kind_at(0, 1) !== 2'd1 || live_cnt !== 2)
            $display("FAIL hs_setup: k0 %0d k1 %0d cnt %0d want 3 1 2", kind_at(0, 0), kind_at(0, 1), live_cnt);
        else passed++;
        hit = 2'b01;
        step();
        total++;
        if (hit_ok !== 2'b01 || escape !== 2'b00 || miss !== 2'b00)
            $display("FAIL hs_pulses: ok %b esc %b miss %b want 01 00 00", hit_ok, escape, miss);
        else passed++;
        total++;
        if (kind_at(0, 0) !== 2'd1 || pic_at(0, 0) !== SPR1 || live_cnt !== 1)
            $display("FAIL hs_front: k0 %0d cnt %0d want 1 1", kind_at(0, 0), live_cnt);
        else passed++;
        hit = 2'b00;
        step();
        total++;
        if (escape !== 2'b01 || live_cnt !== 0)
            $display("FAIL hs_escape: esc %b cnt %0d want 01 0", escape, live_cnt);
        else passed++;
        idle_inputs();
        $display("test_hit_scroll done");
    endtask

    task automatic test_gating();
        gaming = 1; shift = 1; spawn_kind = 4'b0100;
        step();
        gaming = 0; shift = 1; spawn_kind = 4'b0101;
        step();
        total++;
        if (kind_at(1, 5) !== 2'd1 || kind_at(1, 4) !== 2'd0 || live_cnt !== 1)
            $display("FAIL gate_hold: k5 %0d k4 %0d cnt %0d want 1 0 1", kind_at(1, 5), kind_at(1, 4), live_cnt);
        else passed++;
        shift = 0; ready = 1; spawn_kind = '0;
        step();
        total++;
        if (kind_at(1, 4) !== 2'd1 || kind_at(1, 5) !== 2'd0)
            $display("FAIL gate_ready: k4 %0d k5 %0d want 1 0", kind_at(1, 4), kind_at(1, 5));
        else passed++;
        gaming = 1; shift = 1; ready = 1;
        step();
        total++;
        if (kind_at(1, 3) !== 2'd1 || kind_at(1, 2) !== 2'd0 || live_cnt !== 1)
            $display("FAIL gate_single: k3 %0d k2 %0d cnt %0d want 1 0 1", kind_at(1, 3), kind_at(1, 2), live_cnt);
        else passed++;
        idle_inputs();
        $display("test_gating done");
    endtask

    task automatic test_gameover();
        logic [LANES*DEPTH*KIND_W-1:0] all_ones;
        all_ones = {(LANES*DEPTH){2'b01}};
        ready = 1; spawn_kind = 4'b0101;
        for (int i = 0; i < DEPTH; i++) step();
        ready = 0; spawn_kind = '0;
        total++;
        if (live_cnt !== 12 || kind_out !== all_ones)
            $display("FAIL go_full: cnt %0d kind %h want 12 %h", live_cnt, kind_out, all_ones);
        else passed++;
        for (int l = 0; l < LANES; l++) begin
            for (int c = 0; c < DEPTH; c++) begin
                total++;
                if (pic_at(l, c) !== SPR1) $display("FAIL go_pic_%0d_%0d: got %h want %h", l, c, pic_at(l, c), SPR1);
                else passed++;
            end
        end
        gameover = 1; gaming = 1; shift = 1; hit = 2'b11; ready = 1; spawn_kind = 4'b1111;
        step();
        total++;
        if (kind_out !== '0 || pic_out !== '0 || live_cnt !== 0)
            $display("FAIL go_clear: kind %h cnt %0d want 0 0", kind_out, live_cnt);
        else passed++;
        total++;
        if ({hit_ok, miss, escape} !== '0)
            $display("FAIL go_pulses: got %b want 0", {hit_ok, miss, escape});
        else passed++;
        idle_inputs();
        gaming = 1; shift = 1; spawn_kind = 4'b0010;
        step();
        total++;
        if (kind_at(0, 5) !== 2'd2 || live_cnt !== 1)
            $display("FAIL go_resume: k %0d cnt %0d want 2 1", kind_at(0, 5), live_cnt);
        else passed++;
        idle_inputs();
        $display("test_gameover done");
    endtask

    initial begin
        sprite_lut = {SPR3, SPR2, SPR1};
        idle_inputs();
        test_reset();
        test_scroll_through();
        test_punch();
        test_hit_scroll();
        test_gating();
        test_gameover();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
